// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg
// Shared definitions for the FP32 operation scheduler: opcode values, the
// layout of the 66-bit command frame, the scheduler state encoding and a
// helper that splits a raw frame into its fields.
package fp_ctrl_pkg;

  // FPU opcodes carried in the low two bits of every command frame
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  // Frame layout: {B[31:0], A[31:0], opcode[1:0]}
  localparam int FRAME_BITS = 66;
  localparam int OPND_W     = 32;
  localparam int OPC_LSB    = 0;
  localparam int A_LSB      = 2;
  localparam int B_LSB      = 34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [OPND_W-1:0] b;
    logic [OPND_W-1:0] a;
    logic [1:0]        opc;
  } fp_cmd_t;

  // Pulls the opcode and both operands out of a raw frame
  function automatic fp_cmd_t decode_frame(input logic [FRAME_BITS-1:0] frame);
    fp_cmd_t cmd;
    cmd.opc = frame[OPC_LSB +: 2];
    cmd.a   = frame[A_LSB +: OPND_W];
    cmd.b   = frame[B_LSB +: OPND_W];
    return cmd;
  endfunction

endpackage

// File: rtl/fp_op_scheduler_rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter. Grants are combinational so the requester
// sees ready in the same cycle it presents valid. The priority pointer
// moves to the other requester whenever a grant is given; because a grant
// is only raised for a valid request while enabled, every grant is a
// completed handshake.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   en           - arbitration allowed this cycle (scheduler idle)
//   req[1:0]     - request valids, bit N = requester N
//   grant[1:0]   - one-hot grant
//   grant_id     - index of the granted requester (valid when grant != 0)
module rr_arbiter2
  import fp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_q;
  logic ptr_d;

  // Pick the winner: a lone requester wins outright, a tie is broken by the
  // pointer, and the pointer then favours the requester that lost.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    ptr_d    = ptr_q;
    if (en) begin
      if (req[0] && req[1]) begin
        grant_id = ptr_q;
      end else if (req[1]) begin
        grant_id = 1'b1;
      end else begin
        grant_id = 1'b0;
      end
      if (|req) begin
        grant = 2'b01 << grant_id;
        ptr_d = ~grant_id;
      end
    end
  end

  // Pointer register; reset gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp_op_scheduler.sv
// fp_op_scheduler
// Shares one multi-cycle FP32 add/sub/mul unit between two command sources.
// Accepts one frame at a time via round-robin arbitration, issues it to the
// FPU, waits for completion with a timeout, and returns the result tagged
// with the requester ID on a single valid/ready response channel.
// Ports:
//   clk, reset                  - clock and synchronous active-high reset
//   reqN_valid/reqN_frame/ready - command inputs from requester 0 and 1
//   fpu_start/op/a/b/abort      - issue side of the shared FPU
//   fpu_done/fpu_result         - FPU completion
//   rsp_valid/ready/id/result/err - response channel
//   busy                        - scheduler not idle
module fp_op_scheduler
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FRAME_W        = 66
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [FRAME_W-1:0] req0_frame,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [FRAME_W-1:0] req1_frame,
  output logic               req1_ready,
  output logic               fpu_start,
  output logic [1:0]         fpu_op,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic               fpu_abort,
  input  logic               fpu_done,
  input  logic [31:0]        fpu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_err,
  output logic               busy
);

  // Last counter value tolerated in WAIT; reaching it without done aborts
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         fpu_start_q, fpu_start_d;
  logic         fpu_abort_q, fpu_abort_d;
  logic [1:0]   fpu_op_q, fpu_op_d;
  logic [31:0]  fpu_a_q, fpu_a_d;
  logic [31:0]  fpu_b_q, fpu_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [31:0]  rsp_result_q, rsp_result_d;
  logic         rsp_err_q, rsp_err_d;
  logic         busy_q, busy_d;

  logic [1:0]   arb_grant;
  logic         arb_id;
  fp_cmd_t      cmd;

  // Arbitration only happens while idle, which also holds both readies low
  // during ISSUE/WAIT/RESP so response back-pressure stalls both sources.
  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == ST_IDLE),
    .req      ({req1_valid, req0_valid}),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  assign req0_ready = arb_grant[0];
  assign req1_ready = arb_grant[1];
  assign cmd        = decode_frame(arb_id ? req1_frame : req0_frame);

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so start/abort/rsp_valid are registered and line up with
  // the state they belong to. An illegal opcode skips the FPU entirely and
  // leaves its operand registers untouched.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fpu_start_d  = 1'b0;
    fpu_abort_d  = 1'b0;
    fpu_op_d     = fpu_op_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          rsp_id_d = arb_id;
          if (cmd.opc == OP_ILLEGAL) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = 32'd0;
            state_d      = ST_RESP;
          end else begin
            fpu_op_d    = cmd.opc;
            fpu_a_d     = cmd.a;
            fpu_b_d     = cmd.b;
            fpu_start_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // done has priority over a timeout landing in the same cycle
        if (fpu_done) begin
          rsp_result_d = fpu_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fpu_abort_d  = 1'b1;
          rsp_result_d = 32'd0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any command in flight silently
  // because the FPU is reset alongside this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      fpu_start_q  <= 1'b0;
      fpu_abort_q  <= 1'b0;
      fpu_op_q     <= 2'b00;
      fpu_a_q      <= 32'd0;
      fpu_b_q      <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fpu_start_q  <= fpu_start_d;
      fpu_abort_q  <= fpu_abort_d;
      fpu_op_q     <= fpu_op_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign fpu_start  = fpu_start_q;
  assign fpu_abort  = fpu_abort_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_op_scheduler.sv
// tb_fp_op_scheduler
// Self-checking bench for fp_op_scheduler. A small FPU model answers each
// fpu_start after a programmable latency (0 = never). A reference model
// tracks round-robin ownership and predicts, per command, which requester
// wins, when the response appears and what it carries.
module tb_fp_op_scheduler;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        req0_valid;
  logic [65:0] req0_frame;
  logic        req0_ready;
  logic        req1_valid;
  logic [65:0] req1_frame;
  logic        req1_ready;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_abort;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        busy;

  int tests      = 0;
  int failures   = 0;
  int fpu_lat    = 1;
  int model_next = 0;

  fp_op_scheduler #(.TIMEOUT_CYCLES(TMO), .FRAME_W(66)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_frame (req0_frame),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_frame (req1_frame),
    .req1_ready (req1_ready),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_abort  (fpu_abort),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result the FPU produces: true IEEE values for the directed cases, an
  // arbitrary but deterministic word otherwise (the scheduler only forwards it)
  function automatic logic [31:0] fpu_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'b10 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (op == 2'b01 && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return (a ^ {b[15:0], b[31:16]}) + {30'd0, op};
  endfunction

  function automatic logic [65:0] mk_frame(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    return {b, a, op};
  endfunction

  // FPU model: answers fpu_start with a one-cycle done after fpu_lat cycles,
  // forgets the operation on abort or reset
  initial begin
    bit          pending;
    int          countdown;
    logic [31:0] pend_res;
    pending    = 1'b0;
    countdown  = 0;
    pend_res   = 32'd0;
    fpu_done   = 1'b0;
    fpu_result = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      fpu_done = 1'b0;
      if (reset || fpu_abort) begin
        pending = 1'b0;
      end else if (fpu_start) begin
        pending   = (fpu_lat != 0);
        countdown = fpu_lat;
        pend_res  = fpu_ref(fpu_op, fpu_a, fpu_b);
      end else if (pending) begin
        countdown--;
        if (countdown == 0) begin
          fpu_done   = 1'b1;
          fpu_result = pend_res;
          pending    = 1'b0;
        end
      end
    end
  end

  // Hard stop in case the design wedges the stimulus
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [65:0] f0,
                               input logic v1, input logic [65:0] f1);
    req0_valid = v0;
    req0_frame = f0;
    req1_valid = v1;
    req1_frame = f1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete command: handshake, FPU issue, response, optional stall of
  // bp cycles with rsp_ready low, then return to idle.
  task automatic runTxn(input logic v0, input logic [65:0] f0, input logic v1,
                        input logic [65:0] f1, input int lat, input int bp);
    int          win;
    int          exp_cyc;
    int          start_cyc;
    int          start_cnt;
    int          abort_cyc;
    int          abort_cnt;
    int          rsp_cyc;
    bit          busy_low;
    bit          ready_high;
    bit          legal;
    bit          timed_out;
    logic [65:0] wf;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_err;
    start_cyc  = -1;
    start_cnt  = 0;
    abort_cyc  = -1;
    abort_cnt  = 0;
    rsp_cyc    = -1;
    busy_low   = 1'b0;
    ready_high = 1'b0;
    fpu_lat    = lat;
    rsp_ready  = 1'b0;
    applyStimulus(v0, f0, v1, f1);
    #1;
    win = (v0 && v1) ? model_next : (v0 ? 0 : 1);
    checkOutput("req0_ready_grant", req0_ready, 32'(win == 0));
    checkOutput("req1_ready_grant", req1_ready, 32'(win == 1));
    model_next = 1 - win;
    wf = (win == 1) ? f1 : f0;
    op = wf[1:0];
    a  = wf[33:2];
    b  = wf[65:34];
    legal     = (op != 2'b11);
    timed_out = legal && !(lat >= 1 && lat <= TMO);
    if (!legal) begin
      exp_cyc = 1;       exp_err = 1'b1; exp_res = 32'd0;
    end else if (timed_out) begin
      exp_cyc = TMO + 2; exp_err = 1'b1; exp_res = 32'd0;
    end else begin
      exp_cyc = lat + 2; exp_err = 1'b0; exp_res = fpu_ref(op, a, b);
    end
    #1;
    tick;
    for (int c = 1; c <= TMO + 12; c++) begin
      if (fpu_start) begin
        start_cnt++;
        if (start_cyc < 0) begin
          start_cyc = c;
          checkOutput("fpu_op_issue", {30'd0, fpu_op}, {30'd0, op});
          checkOutput("fpu_a_issue", fpu_a, a);
          checkOutput("fpu_b_issue", fpu_b, b);
        end
      end
      if (fpu_abort) begin
        abort_cnt++;
        abort_cyc = c;
      end
      if (!busy) busy_low = 1'b1;
      if (req0_ready || req1_ready) ready_high = 1'b1;
      if (rsp_valid) begin
        rsp_cyc = c;
        break;
      end
      tick;
    end
    checkOutput("rsp_seen", rsp_valid, 1);
    checkOutput("rsp_cycle", rsp_cyc, exp_cyc);
    checkOutput("start_count", start_cnt, legal ? 1 : 0);
    if (legal) begin
      checkOutput("start_cycle", start_cyc, 1);
      checkOutput("fpu_a_hold", fpu_a, a);
      checkOutput("fpu_b_hold", fpu_b, b);
    end
    checkOutput("abort_count", abort_cnt, timed_out ? 1 : 0);
    if (timed_out) checkOutput("abort_cycle", abort_cyc, TMO + 2);
    checkOutput("busy_while_active", busy_low, 0);
    checkOutput("ready_while_active", ready_high, 0);
    checkOutput("rsp_id", rsp_id, win);
    checkOutput("rsp_err", rsp_err, exp_err);
    checkOutput("rsp_result", rsp_result, exp_res);
    for (int k = 0; k < bp; k++) begin
      tick;
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_rsp_id", rsp_id, win);
      checkOutput("bp_rsp_err", rsp_err, exp_err);
      checkOutput("bp_rsp_result", rsp_result, exp_res);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_readies", {req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rsp_valid", rsp_valid, 0);
    checkOutput("idle_abort", fpu_abort, 0);
    applyStimulus(1'b0, f0, 1'b0, f1);
  endtask

  initial begin
    logic [65:0] f_add;
    logic [65:0] f_mul;
    logic [65:0] f_sub;
    logic [65:0] f_ill;
    bit          abort_after_reset;
    f_add = mk_frame(2'b00, 32'h3F80_0000, 32'h4000_0000);
    f_mul = mk_frame(2'b10, 32'h4000_0000, 32'h4040_0000);
    f_sub = mk_frame(2'b01, 32'h4040_0000, 32'h3F80_0000);
    f_ill = mk_frame(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);

    reset     = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 66'd0, 1'b0, 66'd0);
    tick;
    tick;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_result", rsp_result, 0);
    checkOutput("reset_fpu_start", fpu_start, 0);
    checkOutput("reset_fpu_a", fpu_a, 0);
    reset = 1'b0;
    model_next = 0;

    // Both requesters valid from reset: three pairs alternating 0,1
    for (int p = 0; p < 6; p++) runTxn(1'b1, f_mul, 1'b1, f_sub, 3, 0);

    // Single add from requester 0 with a 3-cycle FPU
    runTxn(1'b1, f_add, 1'b0, f_sub, 3, 0);

    // Illegal opcode from requester 1
    runTxn(1'b0, f_add, 1'b1, f_ill, 3, 0);

    // FPU never answers, then answers exactly at the last counter value
    runTxn(1'b1, f_add, 1'b0, f_add, 0, 0);
    runTxn(1'b1, f_mul, 1'b0, f_add, TMO, 0);

    // Response held off for 10 cycles with both sources pushing
    runTxn(1'b1, f_sub, 1'b1, f_mul, 2, 10);

    // Reset while in WAIT: pointer is on requester 1 beforehand
    runTxn(1'b1, f_add, 1'b0, f_add, 2, 0);
    fpu_lat = 0;
    applyStimulus(1'b1, f_mul, 1'b0, f_sub);
    tick;
    applyStimulus(1'b0, f_mul, 1'b0, f_sub);
    tick;
    tick;
    tick;
    checkOutput("wait_busy_before_reset", busy, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_next = 0;
    checkOutput("rst_wait_busy", busy, 0);
    checkOutput("rst_wait_fpu_start", fpu_start, 0);
    checkOutput("rst_wait_fpu_abort", fpu_abort, 0);
    checkOutput("rst_wait_fpu_op", {30'd0, fpu_op}, 0);
    checkOutput("rst_wait_fpu_a", fpu_a, 0);
    checkOutput("rst_wait_fpu_b", fpu_b, 0);
    checkOutput("rst_wait_rsp_valid", rsp_valid, 0);
    checkOutput("rst_wait_rsp_id", rsp_id, 0);
    checkOutput("rst_wait_rsp_err", rsp_err, 0);
    checkOutput("rst_wait_rsp_result", rsp_result, 0);
    abort_after_reset = 1'b0;
    for (int k = 0; k < TMO + 4; k++) begin
      if (fpu_abort || rsp_valid || busy) abort_after_reset = 1'b1;
      tick;
    end
    checkOutput("rst_wait_quiet", abort_after_reset, 0);
    runTxn(1'b1, f_add, 1'b1, f_sub, 3, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          pat;
      logic [65:0] r0;
      logic [65:0] r1;
      pat = $urandom_range(1, 3);
      r0  = mk_frame(2'($urandom_range(0, 3)), $urandom, $urandom);
      r1  = mk_frame(2'($urandom_range(0, 3)), $urandom, $urandom);
      runTxn(pat[0], r0, pat[1], r1, $urandom_range(0, TMO + 1), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
